// File: rtl/rot_column_scanner.sv
// rot_column_scanner: turns a hall index pulse into angular slots and
// shifts two opposite frame-buffer columns out to the LED blade each slot.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   index_in                  once-per-rev index (rising edge = theta 0)
//   buffer_busy_in            frame buffer busy; fetch stalls while high
//   theta_read_out            buffer read address
//   columns_in, radii_in      arm 0/1 column data and radius tags
//   led_sclk_out              shift clock
//   led_data_out              serial data, bit0 arm 0, bit1 arm 1
//   led_latch_out             one-cycle latch strobe
//   radii_out                 radii of the latched columns
//   period_out                last revolution period in cycles
//   period_valid_out          period_out usable
//   overrun_out               sticky: slot start before latch done
// Optional macro ROT_SCANNER_PHASE_OFFSET_EN adds phase_offset_in,
// which is sampled at each index edge and added to the slot angle.
module rot_column_scanner #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int DISPLAY_RADIUS = 32,
  parameter int DISPLAY_HEIGHT = 64,
  parameter int DATA_SIZE      = 1,
  parameter int READ_LATENCY   = 2,
  parameter int PERIOD_WIDTH   = 32,
  parameter int SCLK_DIV       = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic index_in,
  input  logic buffer_busy_in,
`ifdef ROT_SCANNER_PHASE_OFFSET_EN
  input  logic [$clog2(ROTATIONAL_RES)-1:0] phase_offset_in,
`endif
  output logic [$clog2(ROTATIONAL_RES)-1:0] theta_read_out,
  input  logic [1:0][DISPLAY_HEIGHT*DATA_SIZE-1:0] columns_in,
  input  logic [1:0][$clog2(DISPLAY_RADIUS)-1:0] radii_in,
  output logic led_sclk_out,
  output logic [1:0] led_data_out,
  output logic led_latch_out,
  output logic [1:0][$clog2(DISPLAY_RADIUS)-1:0] radii_out,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic period_valid_out,
  output logic overrun_out
);

  localparam int TW  = $clog2(ROTATIONAL_RES);
  localparam int RW  = $clog2(DISPLAY_RADIUS);
  localparam int CW  = DISPLAY_HEIGHT * DATA_SIZE;
  localparam int PW  = PERIOD_WIDTH;
  localparam int WCW = $clog2(READ_LATENCY + 2);
  localparam int DW  = $clog2(SCLK_DIV + 1);
  localparam int BW  = $clog2(CW + 1);

  localparam logic [PW-1:0]  CNT_MAX  = '1;
  localparam logic [WCW-1:0] WAIT_LD  = WCW'(READ_LATENCY);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(CW - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SHIFT,
    LATCH,
    HOLD
  } state_t;

  logic          index_q;
  logic          index_rise;
  logic [PW-1:0] counter;
  logic          seen_one;
  logic          sat;

  logic [PW-1:0] slot_len;
  logic [PW-1:0] slot_cnt;
  logic [TW-1:0] slot_theta;
  logic          wrap;
  logic          slot_start;

  state_t                  state;
  logic [WCW-1:0]          wait_cnt;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [CW-1:0]           sr0;
  logic [CW-1:0]           sr1;
  logic [CW-1:0]           nxt0;
  logic [CW-1:0]           nxt1;
  logic [1:0][RW-1:0]      rsr;
  logic                    pending;
  logic                    busy_state;

  assign index_rise = index_in & ~index_q;
  assign sat = (counter == CNT_MAX) && !index_rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      index_q          <= 1'b0;
      counter          <= '0;
      period_out       <= '0;
      seen_one         <= 1'b0;
      period_valid_out <= 1'b0;
    end else begin
      index_q <= index_in;
      if (index_rise) begin
        period_out <= counter + 1'b1;
        counter    <= '0;
        seen_one   <= 1'b1;
        if (seen_one)
          period_valid_out <= 1'b1;
      end else if (counter == CNT_MAX) begin
        // stalled rotor: need two fresh edges
        period_valid_out <= 1'b0;
        seen_one         <= 1'b0;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

  always_comb begin
    slot_len = period_out >> TW;
    if (slot_len == '0)
      slot_len = PW'(1);
  end

  assign wrap = period_valid_out &&
                (slot_cnt >= slot_len - 1'b1);
  assign slot_start = index_rise | wrap;

`ifdef ROT_SCANNER_PHASE_OFFSET_EN
  logic [TW-1:0] phase_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_cnt   <= '0;
      slot_theta <= '0;
`ifdef ROT_SCANNER_PHASE_OFFSET_EN
      phase_q    <= '0;
`endif
    end else if (index_rise) begin
      slot_cnt   <= '0;
      slot_theta <= '0;
`ifdef ROT_SCANNER_PHASE_OFFSET_EN
      phase_q    <= phase_offset_in;
`endif
    end else if (!period_valid_out) begin
      slot_cnt   <= '0;
      slot_theta <= '0;
    end else if (wrap) begin
      slot_cnt   <= '0;
      slot_theta <= slot_theta + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

`ifdef ROT_SCANNER_PHASE_OFFSET_EN
  assign theta_read_out = slot_theta + phase_q;
`else
  assign theta_read_out = slot_theta;
`endif

  assign nxt0 = sr0 << 1;
  assign nxt1 = sr1 << 1;
  assign busy_state = (state == FETCH) ||
                      (state == WAIT_DATA) ||
                      (state == SHIFT) ||
                      (state == LATCH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      sr0           <= '0;
      sr1           <= '0;
      rsr           <= '0;
      pending       <= 1'b0;
      led_sclk_out  <= 1'b0;
      led_data_out  <= '0;
      led_latch_out <= 1'b0;
      radii_out     <= '0;
      overrun_out   <= 1'b0;
    end else if (!period_valid_out || sat) begin
      state         <= IDLE;
      pending       <= 1'b0;
      led_sclk_out  <= 1'b0;
      led_data_out  <= '0;
      led_latch_out <= 1'b0;
    end else begin
      // a missed slot is flagged and folded into one refetch
      if (slot_start && busy_state) begin
        overrun_out <= 1'b1;
        pending     <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (slot_start)
            state <= FETCH;
        end
        FETCH: begin
          if (!buffer_busy_in) begin
            state    <= WAIT_DATA;
            wait_cnt <= WAIT_LD;
          end
        end
        WAIT_DATA: begin
          if (wait_cnt <= WAIT_ONE) begin
            sr0          <= columns_in[0];
            sr1          <= columns_in[1];
            rsr          <= radii_in;
            led_data_out <= {columns_in[1][CW-1],
                             columns_in[0][CW-1]};
            led_sclk_out <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            state        <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!led_sclk_out) begin
              led_sclk_out <= 1'b1;
            end else begin
              led_sclk_out <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state         <= LATCH;
                led_latch_out <= 1'b1;
                led_data_out  <= '0;
                radii_out     <= rsr;
              end else begin
                bit_cnt      <= bit_cnt + 1'b1;
                sr0          <= nxt0;
                sr1          <= nxt1;
                led_data_out <= {nxt1[CW-1], nxt0[CW-1]};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          led_latch_out <= 1'b0;
          pending       <= 1'b0;
          if (pending || slot_start)
            state <= FETCH;
          else
            state <= HOLD;
        end
        HOLD: begin
          if (slot_start)
            state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_column_scanner.sv
// tb_rot_column_scanner: randomized bench for rot_column_scanner with a
// behavioural frame-buffer model and a serial-stream collector.
module tb_rot_column_scanner;

  localparam int RES = 8;
  localparam int RAD = 32;
  localparam int H   = 4;
  localparam int D   = 1;
  localparam int RL  = 2;
  localparam int PW  = 16;
  localparam int SD  = 1;
  localparam int CW  = H * D;

  logic clk = 1'b0;
  logic rst;
  logic index;
  logic busy;
  logic [2:0] theta;
  logic [1:0][CW-1:0] columns;
  logic [1:0][4:0] radii_i;
  logic [1:0][4:0] radii_o;
  logic sclk;
  logic [1:0] data;
  logic latch;
  logic [PW-1:0] period;
  logic valid;
  logic overrun;
`ifdef ROT_SCANNER_PHASE_OFFSET_EN
  logic [2:0] phase = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rot_column_scanner #(
    .ROTATIONAL_RES(RES),
    .DISPLAY_RADIUS(RAD),
    .DISPLAY_HEIGHT(H),
    .DATA_SIZE(D),
    .READ_LATENCY(RL),
    .PERIOD_WIDTH(PW),
    .SCLK_DIV(SD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .index_in(index),
    .buffer_busy_in(busy),
`ifdef ROT_SCANNER_PHASE_OFFSET_EN
    .phase_offset_in(phase),
`endif
    .theta_read_out(theta),
    .columns_in(columns),
    .radii_in(radii_i),
    .led_sclk_out(sclk),
    .led_data_out(data),
    .led_latch_out(latch),
    .radii_out(radii_o),
    .period_out(period),
    .period_valid_out(valid),
    .overrun_out(overrun)
  );

  // frame buffer model: data follows the address RL clocks later
  logic [CW-1:0] m0 [RES];
  logic [CW-1:0] m1 [RES];
  logic [4:0]    r0 [RES];
  logic [4:0]    r1 [RES];
  logic [2:0] th1 = '0;
  logic [2:0] th2 = '0;

  always @(posedge clk) begin
    th1 <= theta;
    th2 <= th1;
  end

  assign columns[0] = m0[th2];
  assign columns[1] = m1[th2];
  assign radii_i[0] = r0[th2];
  assign radii_i[1] = r1[th2];

  typedef struct {
    logic [CW-1:0] b0;
    logic [CW-1:0] b1;
    int            n;
    int            th;
    logic [4:0]    ra0;
    logic [4:0]    ra1;
  } rec_t;

  rec_t q[$];
  rec_t cr;
  logic [CW-1:0] acc0 = '0;
  logic [CW-1:0] acc1 = '0;
  int nr = 0;
  logic psclk = 1'b0;

  // collects bits on each sclk rise and one record per latch
  always @(negedge clk) begin
    if (rst || !valid) begin
      acc0 = '0;
      acc1 = '0;
      nr = 0;
    end else begin
      if (sclk && !psclk) begin
        acc0 = {acc0[CW-2:0], data[0]};
        acc1 = {acc1[CW-2:0], data[1]};
        nr++;
      end
      if (latch) begin
        cr.b0 = acc0;
        cr.b1 = acc1;
        cr.n = nr;
        cr.th = int'(theta);
        cr.ra0 = radii_o[0];
        cr.ra1 = radii_o[1];
        q.push_back(cr);
        acc0 = '0;
        acc1 = '0;
        nr = 0;
      end
    end
    psclk = sclk;
  end

  task automatic spin(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      index = 1'b1;
      @(negedge clk);
      index = 1'b0;
      repeat (p - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    index = 1'b0;
    busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (theta !== 3'd0) begin
      errors++;
      $display("FAIL reset_theta got %0d want 0", theta);
    end
    checks++;
    if ({sclk, data, latch} !== 4'b0) begin
      errors++;
      $display("FAIL reset_led got %b want 0000",
               {sclk, data, latch});
    end
    checks++;
    if (radii_o !== '0) begin
      errors++;
      $display("FAIL reset_radii got %h want 0", radii_o);
    end
    checks++;
    if (period !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_period got %0d/%b want 0/0",
               period, valid);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got %b want 0", overrun);
    end
  endtask

  task automatic test_period;
    int slot;
    int exp;
    slot = 800 / RES;
    spin(800, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL period_first_edge valid got %b want 0", valid);
    end
    index = 1'b1;
    @(negedge clk);
    index = 1'b0;
    checks++;
    if (period !== 16'd800 || valid !== 1'b1) begin
      errors++;
      $display("FAIL period_measure got %0d/%b want 800/1",
               period, valid);
    end
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      exp = (i / slot) % RES;
      checks++;
      if (int'(theta) != exp) begin
        errors++;
        $display("FAIL theta_step cyc %0d got %0d want %0d",
                 i, theta, exp);
      end
    end
  endtask

  task automatic check_recs(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].n != CW ||
          q[i].b0 !== m0[q[i].th] ||
          q[i].b1 !== m1[q[i].th] ||
          q[i].ra0 !== r0[q[i].th] ||
          q[i].ra1 !== r1[q[i].th]) begin
        errors++;
        $display("FAIL %s th %0d got n%0d %b %b r%0d,%0d want n%0d %b %b r%0d,%0d",
                 tag, q[i].th, q[i].n, q[i].b0, q[i].b1,
                 q[i].ra1, q[i].ra0, CW, m0[q[i].th],
                 m1[q[i].th], r1[q[i].th], r0[q[i].th]);
      end
    end
  endtask

  task automatic test_steady;
    q.delete();
    spin(800, 2);
    checks++;
    if (q.size() != 2 * RES) begin
      errors++;
      $display("FAIL steady_count got %0d want %0d",
               q.size(), 2 * RES);
    end
    check_recs("steady_column");
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL steady_overrun got %b want 0", overrun);
    end
  endtask

  task automatic test_busy;
    int k;
    q.delete();
    index = 1'b1;
    busy = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      index = 1'b0;
      checks++;
      if (theta !== 3'd0 || sclk !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold cyc %0d got th%0d sclk%b want th0 sclk0",
                 j, theta, sclk);
      end
    end
    busy = 1'b0;
    k = 0;
    while (sclk !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 1 + RL + SD) begin
      errors++;
      $display("FAIL busy_latency got %0d want %0d", k, 1 + RL + SD);
    end
    repeat (800 - 1 - 20 - k) @(negedge clk);
    checks++;
    if (q.size() != RES) begin
      errors++;
      $display("FAIL busy_count got %0d want %0d", q.size(), RES);
    end
    check_recs("busy_column");
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL busy_overrun got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun;
    q.delete();
    spin(40, 8);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    checks++;
    if (q.size() < 4) begin
      errors++;
      $display("FAIL overrun_columns got %0d want >=4", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].n != CW) begin
        errors++;
        $display("FAIL overrun_bits got %0d want %0d", q[i].n, CW);
      end
    end
    spin(40, 2);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got %b want 1", overrun);
    end
  endtask

  task automatic test_stall;
    repeat (65540) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_valid got %b want 0", valid);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({sclk, data, latch} !== 4'b0) begin
        errors++;
        $display("FAIL stall_led got %b want 0000",
                 {sclk, data, latch});
      end
      @(negedge clk);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL stall_overrun got %b want 1", overrun);
    end
    spin(800, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_one_edge valid got %b want 0", valid);
    end
    q.delete();
    spin(800, 1);
    checks++;
    if (valid !== 1'b1 || period !== 16'd800) begin
      errors++;
      $display("FAIL stall_resume got %0d/%b want 800/1",
               period, valid);
    end
    checks++;
    if (q.size() < RES - 1 || q.size() > RES) begin
      errors++;
      $display("FAIL stall_resume_count got %0d want %0d..%0d",
               q.size(), RES - 1, RES);
    end
    check_recs("stall_column");
  endtask

  task automatic test_reset_mid;
    int k;
    index = 1'b1;
    @(negedge clk);
    index = 1'b0;
    k = 0;
    while (sclk !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sclk !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait got sclk %b want 1", sclk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sclk, data, latch, valid, overrun} !== 6'b0 ||
        theta !== 3'd0 || radii_o !== '0 || period !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %b th%0d r%h p%0d want 0",
               {sclk, data, latch, valid, overrun},
               theta, radii_o, period);
    end
    rst = 1'b0;
    q.delete();
    spin(800, 1);
    checks++;
    if (valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_one_edge got v%b cols%0d want v0 cols0",
               valid, q.size());
    end
    spin(800, 1);
    checks++;
    if (valid !== 1'b1 || q.size() < RES - 1) begin
      errors++;
      $display("FAIL rstmid_resume got v%b cols%0d want v1 cols>=%0d",
               valid, q.size(), RES - 1);
    end
    check_recs("rstmid_column");
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_overrun got %b want 0", overrun);
    end
  endtask

  initial begin
    rst = 1'b1;
    index = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < RES; i++) begin
      m0[i] = CW'($urandom);
      m1[i] = CW'($urandom);
      r0[i] = 5'($urandom);
      r1[i] = 5'($urandom);
    end
    m0[3] = 4'b1010;
    m1[3] = 4'b0110;
    r0[3] = 5'd3;
    r1[3] = 5'd5;
    @(negedge clk);
    test_reset();
    test_period();
    test_steady();
    test_busy();
    test_overrun();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
